// File: rtl/priority_decoder_dispatch_pkg.sv
// Shared definitions for the priority-index dispatch path: default widths and FSM encodings.
package prio_pkg;

   localparam int PRIO_IDX_W      = 3;
   localparam int PRIO_OUT_W      = 1 << PRIO_IDX_W;
   localparam int PRIO_FIFO_DEPTH = 2;
   localparam int PRIO_CNT_W      = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/priority_decoder_dispatch_fifo.sv
// Small synchronous FIFO buffering encoded indices; pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module prio_idx_fifo
   import prio_pkg::*;
#(
   parameter int W     = PRIO_IDX_W,
   parameter int DEPTH = PRIO_FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_mem [DEPTH];
   logic         w_do_push;
   logic         w_do_pop;

   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer and storage update; flush only rewinds the pointers, stale data is never read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= {(AW+1){1'b0}};
         r_rd_ptr <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {W{1'b0}};
         end
      end else if (flush) begin
         r_wr_ptr <= {(AW+1){1'b0}};
         r_rd_ptr <= {(AW+1){1'b0}};
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
            r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/priority_decoder_dispatch.sv
// Receives encoded priority indices, buffers them, and holds the decoded one-hot line
// until the consumer acknowledges it; acknowledged dispatches are counted with saturation.
module priority_decoder_dispatch
   import prio_pkg::*;
#(
   parameter int IDX_W      = PRIO_IDX_W,
   parameter int OUT_W      = PRIO_OUT_W,
   parameter int FIFO_DEPTH = PRIO_FIFO_DEPTH,
   parameter int CNT_W      = PRIO_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             idx_valid,
   input  logic [IDX_W-1:0] idx,
   output logic             idx_ready,
   output logic [OUT_W-1:0] onehot,
   output logic             onehot_valid,
   input  logic             onehot_ack,
   output logic [CNT_W-1:0] dispatch_cnt
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [OUT_W-1:0] r_onehot;
   logic [OUT_W-1:0] w_onehot_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_alive;
   logic             w_pop;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [IDX_W-1:0] w_head;
   logic [OUT_W-1:0] w_head_dec;
   logic [OUT_W-1:0] w_one;

   // r_alive keeps idx_ready low through reset and until the first post-reset edge.
   assign idx_ready  = r_alive & en & ~w_full;
   assign w_push     = idx_valid & idx_ready;
   assign w_one      = {{(OUT_W-1){1'b0}}, 1'b1};
   assign w_head_dec = w_one << w_head;

   prio_idx_fifo #(
      .W     (IDX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (~en),
      .push  (w_push),
      .pop   (w_pop),
      .din   (idx),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   // Next-state, next-output and pop decision for the dispatch FSM.
   always_comb begin
      w_state_nxt  = r_state;
      w_onehot_nxt = r_onehot;
      w_valid_nxt  = r_valid;
      w_cnt_nxt    = r_cnt;
      w_pop        = 1'b0;
      if (!en) begin
         w_state_nxt  = S_IDLE;
         w_onehot_nxt = {OUT_W{1'b0}};
         w_valid_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_onehot_nxt = w_head_dec;
                  w_valid_nxt  = 1'b1;
                  w_state_nxt  = S_HOLD;
               end else begin
                  w_onehot_nxt = {OUT_W{1'b0}};
                  w_valid_nxt  = 1'b0;
               end
            end
            S_HOLD: begin
               if (onehot_ack) begin
                  if (r_cnt != {CNT_W{1'b1}}) begin
                     w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     w_cnt_nxt = r_cnt;
                  end
                  // Back-to-back reload keeps one dispatch per cycle while ack stays high.
                  if (!w_empty) begin
                     w_pop        = 1'b1;
                     w_onehot_nxt = w_head_dec;
                     w_valid_nxt  = 1'b1;
                  end else begin
                     w_onehot_nxt = {OUT_W{1'b0}};
                     w_valid_nxt  = 1'b0;
                     w_state_nxt  = S_IDLE;
                  end
               end else begin
                  w_onehot_nxt = r_onehot;
                  w_valid_nxt  = 1'b1;
               end
            end
            default: begin
               w_state_nxt  = S_IDLE;
               w_onehot_nxt = {OUT_W{1'b0}};
               w_valid_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State, output and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_onehot <= {OUT_W{1'b0}};
         r_valid  <= 1'b0;
         r_cnt    <= {CNT_W{1'b0}};
         r_alive  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_onehot <= w_onehot_nxt;
         r_valid  <= w_valid_nxt;
         r_cnt    <= w_cnt_nxt;
         r_alive  <= 1'b1;
      end
   end

   assign onehot       = r_onehot;
   assign onehot_valid = r_valid;
   assign dispatch_cnt = r_cnt;

endmodule

// File: tb/tb_priority_decoder_dispatch.sv
// Directed bench: default-width instance plus a CNT_W=2 instance for saturation, shared stimulus.
module tb_priority_decoder_dispatch;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       idx_valid;
   logic [2:0] idx;
   logic       onehot_ack;

   logic       idx_ready;
   logic [7:0] onehot;
   logic       onehot_valid;
   logic [7:0] dispatch_cnt;

   logic       s_idx_ready;
   logic [7:0] s_onehot;
   logic       s_onehot_valid;
   logic [1:0] s_dispatch_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   priority_decoder_dispatch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .idx_valid    (idx_valid),
      .idx          (idx),
      .idx_ready    (idx_ready),
      .onehot       (onehot),
      .onehot_valid (onehot_valid),
      .onehot_ack   (onehot_ack),
      .dispatch_cnt (dispatch_cnt)
   );

   priority_decoder_dispatch #(.CNT_W(2)) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .idx_valid    (idx_valid),
      .idx          (idx),
      .idx_ready    (s_idx_ready),
      .onehot       (s_onehot),
      .onehot_valid (s_onehot_valid),
      .onehot_ack   (onehot_ack),
      .dispatch_cnt (s_dispatch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int sat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      rst_n      = 1'b0;
      en         = 1'b1;
      idx_valid  = 1'b1;
      idx        = 3'd7;
      onehot_ack = 1'b0;

      // 1 reset
      tick();
      tick();
      chk("rst_onehot", 32'(onehot), 32'h0);
      chk("rst_valid", 32'(onehot_valid), 32'h0);
      chk("rst_ready", 32'(idx_ready), 32'h0);
      chk("rst_cnt", 32'(dispatch_cnt), 32'h0);
      rst_n     = 1'b1;
      idx_valid = 1'b0;
      tick();
      chk("rel_ready", 32'(idx_ready), 32'h1);
      chk("rel_valid", 32'(onehot_valid), 32'h0);

      // 2 single dispatch
      idx_valid = 1'b1;
      idx       = 3'd7;
      tick();
      idx_valid = 1'b0;
      chk("single_lat_valid", 32'(onehot_valid), 32'h0);
      tick();
      chk("single_onehot", 32'(onehot), 32'h80);
      chk("single_valid", 32'(onehot_valid), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("single_hold", {23'h0, onehot_valid, onehot}, 32'h180);
      end
      onehot_ack = 1'b1;
      tick();
      onehot_ack = 1'b0;
      chk("single_done_onehot", 32'(onehot), 32'h0);
      chk("single_done_valid", 32'(onehot_valid), 32'h0);
      chk("single_cnt", 32'(dispatch_cnt), 32'h1);

      // 3 back-to-back with ack held
      onehot_ack = 1'b1;
      idx_valid  = 1'b1;
      idx        = 3'd7;
      tick();
      idx = 3'd6;
      tick();
      chk("b2b_0", 32'(onehot), 32'h80);
      idx = 3'd0;
      tick();
      chk("b2b_1", 32'(onehot), 32'h40);
      idx_valid = 1'b0;
      tick();
      chk("b2b_2", {23'h0, onehot_valid, onehot}, 32'h101);
      tick();
      onehot_ack = 1'b0;
      chk("b2b_end_valid", 32'(onehot_valid), 32'h0);
      chk("b2b_cnt", 32'(dispatch_cnt), 32'h4);

      // 4 fill the FIFO
      idx_valid = 1'b1;
      idx       = 3'd3;
      tick();
      idx = 3'd5;
      tick();
      chk("full_show3", 32'(onehot), 32'h08);
      idx = 3'd1;
      tick();
      idx_valid = 1'b0;
      chk("full_ready", 32'(idx_ready), 32'h0);
      chk("full_hold3", 32'(onehot), 32'h08);
      onehot_ack = 1'b1;
      tick();
      onehot_ack = 1'b0;
      chk("full_show5", 32'(onehot), 32'h20);
      chk("full_ready_back", 32'(idx_ready), 32'h1);
      chk("full_cnt", 32'(dispatch_cnt), 32'h5);

      // 5 en drop with two queued
      idx_valid = 1'b1;
      idx       = 3'd2;
      tick();
      idx_valid = 1'b0;
      chk("en_pre_ready", 32'(idx_ready), 32'h0);
      en = 1'b0;
      tick();
      chk("en_off_onehot", 32'(onehot), 32'h0);
      chk("en_off_valid", 32'(onehot_valid), 32'h0);
      chk("en_off_ready", 32'(idx_ready), 32'h0);
      chk("en_off_cnt", 32'(dispatch_cnt), 32'h5);
      en = 1'b1;
      tick();
      chk("en_on_valid", 32'(onehot_valid), 32'h0);
      chk("en_on_ready", 32'(idx_ready), 32'h1);
      tick();
      chk("en_on_idle", {23'h0, onehot_valid, onehot}, 32'h0);

      // 6 saturation on the CNT_W=2 instance
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("sat_rst_cnt", 32'(s_dispatch_cnt), 32'h0);
      for (int i = 0; i < 5; i++) begin
         idx_valid = 1'b1;
         idx       = 3'(i);
         tick();
         idx_valid = 1'b0;
         tick();
         chk("sat_onehot", 32'(s_onehot), 32'h1 << i);
         onehot_ack = 1'b1;
         tick();
         onehot_ack = 1'b0;
         chk("sat_cnt", 32'(s_dispatch_cnt), 32'(sat_exp[i]));
         chk("wide_cnt", 32'(dispatch_cnt), 32'(i + 1));
      end
      onehot_ack = 1'b1;
      tick();
      tick();
      onehot_ack = 1'b0;
      chk("idle_ack_sat", 32'(s_dispatch_cnt), 32'h3);
      chk("idle_ack_wide", 32'(dispatch_cnt), 32'h5);
      chk("idle_ack_valid", 32'(onehot_valid), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
